cache_refill_ctrl: RTL and testbench

//  Sequences cache-line refills from main memory into the main-to-cache line FIFO.

---
 rtl/cache_refill_ctrl_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 33 +++
 rtl/cache_refill_ctrl.sv | 131 +++++++++++++
 tb/tb_cache_refill_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared constants, state encodings and payload types for the cache refill controller.
package cache_refill_ctrl_pkg;

    localparam int unsigned LINE_WIDTH     = 512;
    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned OFFSET_BITS    = 6;
    localparam int unsigned INDEX_BITS     = 7;
    localparam int unsigned TIMEOUT_CYCLES = 1023;

    localparam int unsigned LADDR_WIDTH = ADDR_WIDTH - OFFSET_BITS;
    localparam int unsigned TMO_WIDTH   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_REQ  = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_PUSH     = 2'd3;

    // Accepted miss: requesting cache and the line address (offset bits dropped).
    typedef struct packed {
        logic                   src;
        logic [LADDR_WIDTH-1:0] line_addr;
    } refill_req_t;

    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [LADDR_WIDTH-1:0] la);
        return {la, {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; a tie goes to the side that did not win last.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant_c
);

    logic last_grant_q;

    always_comb begin
        grant_c = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = last_grant_q ? 2'b01 : 2'b10;
                default: grant_c = 2'b00;
            endcase
        end
    end

    // Reset to 1 so the I-cache (bit 0) wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else if (|grant_c) begin
            last_grant_q <= grant_c[1];
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Refill sequencer: arbitrates I/D misses, reads one line from memory, pushes it into the line FIFO.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    input  logic                  dc_req_valid,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    output logic                  dc_req_ready,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data,
    input  logic                  fifo_full,
    input  logic                  fifo_is_read,
    output logic                  fifo_is_write,
    output logic [LINE_WIDTH-1:0] fifo_write_data,
    output logic [INDEX_BITS-1:0] fifo_write_addr,
    output logic                  refill_src,
    output logic                  busy,
    output logic                  timeout_err
);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    refill_req_t           req_q;
    logic [LINE_WIDTH-1:0] line_q;
    logic [TMO_WIDTH-1:0]  tmo_cnt_q;
    logic                  timeout_err_q;
    logic [1:0]            grant;
    logic                  arb_en;
    logic                  push_ok;
    logic                  tmo_hit;
    logic                  addr_offset_unused;

    // The byte offset within the line never reaches memory or the FIFO.
    assign addr_offset_unused = ^{ic_req_addr[OFFSET_BITS-1:0], dc_req_addr[OFFSET_BITS-1:0]};

    assign arb_en = (state_q == ST_IDLE);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (arb_en),
        .req     ({dc_req_valid, ic_req_valid}),
        .grant_c (grant)
    );

    // A write the FIFO would drop (full, or read in the same cycle) is held off.
    assign push_ok = (state_q == ST_PUSH) & ~fifo_full & ~fifo_is_read;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    state_d = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = ST_PUSH;
                end else if (tmo_cnt_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    tmo_hit = 1'b1;
                end
            end
            ST_PUSH: begin
                if (push_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, wait counter, line buffer and timeout pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q         <= '0;
            line_q        <= '0;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= tmo_hit;
            if (|grant) begin
                req_q.src       <= grant[1];
                req_q.line_addr <= grant[1] ? dc_req_addr[ADDR_WIDTH-1:OFFSET_BITS]
                                            : ic_req_addr[ADDR_WIDTH-1:OFFSET_BITS];
            end
            if ((state_q == ST_MEM_REQ) && mem_req_ready) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ST_MEM_WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_WIDTH'(1);
            end
            if ((state_q == ST_MEM_WAIT) && mem_rsp_valid) begin
                line_q <= mem_rsp_data;
            end
        end
    end

    assign ic_req_ready    = grant[0];
    assign dc_req_ready    = grant[1];
    assign mem_req_valid   = (state_q == ST_MEM_REQ);
    assign mem_req_addr    = line_base(req_q.line_addr);
    assign fifo_is_write   = push_ok;
    assign fifo_write_data = line_q;
    assign fifo_write_addr = req_q.line_addr[INDEX_BITS-1:0];
    assign refill_src      = req_q.src;
    assign busy            = (state_q != ST_IDLE);
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed vectors, corner sequences and random traffic.
module tb_cache_refill_ctrl;

    localparam int unsigned LW  = 512;
    localparam int unsigned AW  = 32;
    localparam int unsigned OB  = 6;
    localparam int unsigned IB  = 7;
    localparam int          TMO = 1023;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ic_req_valid, dc_req_valid;
    logic [AW-1:0] ic_req_addr, dc_req_addr;
    logic          ic_req_ready, dc_req_ready;
    logic          mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [LW-1:0] mem_rsp_data;
    logic          fifo_full, fifo_is_read, fifo_is_write;
    logic [LW-1:0] fifo_write_data;
    logic [IB-1:0] fifo_write_addr;
    logic          refill_src, busy, timeout_err;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ic_req_valid    (ic_req_valid),
        .ic_req_addr     (ic_req_addr),
        .ic_req_ready    (ic_req_ready),
        .dc_req_valid    (dc_req_valid),
        .dc_req_addr     (dc_req_addr),
        .dc_req_ready    (dc_req_ready),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_req_ready   (mem_req_ready),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .fifo_full       (fifo_full),
        .fifo_is_read    (fifo_is_read),
        .fifo_is_write   (fifo_is_write),
        .fifo_write_data (fifo_write_data),
        .fifo_write_addr (fifo_write_addr),
        .refill_src      (refill_src),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one outstanding job described by its phase.
    bit            m_active;
    int            m_stage;      // 0 waiting for memory accept, 1 waiting for data, 2 holding data
    logic [AW-1:0] m_addr;
    bit            m_src;
    logic [LW-1:0] m_line;
    int            m_waits;
    bit            m_last_d;
    bit            m_tmo_pulse;
    int            n_accept = 0, n_push = 0, n_tmo = 0, n_drop = 0;
    int            n_wr_obs = 0, n_tmo_obs = 0;
    bit            acc_i, acc_d;
    int            obs_src[$];
    logic [LW-1:0] last_wdata;
    bit            count_wait = 0;
    int            wait_cycles = 0;

    typedef struct {
        logic          icv;
        logic [AW-1:0] ica;
        logic          dcv;
        logic [AW-1:0] dca;
        logic          mrr, rspv, full, rd;
        logic          e_icr, e_dcr, e_mv, e_w, e_busy, e_src;
        logic [AW-1:0] e_maddr;
        logic [IB-1:0] e_widx;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mkv(input logic icv, input logic [AW-1:0] ica,
                                 input logic dcv, input logic [AW-1:0] dca,
                                 input logic mrr, input logic rspv, input logic full, input logic rd,
                                 input logic e_icr, input logic e_dcr, input logic e_mv, input logic e_w,
                                 input logic e_busy, input logic e_src,
                                 input logic [AW-1:0] e_maddr, input logic [IB-1:0] e_widx);
        vec_t v;
        v.icv = icv; v.ica = ica; v.dcv = dcv; v.dca = dca;
        v.mrr = mrr; v.rspv = rspv; v.full = full; v.rd = rd;
        v.e_icr = e_icr; v.e_dcr = e_dcr; v.e_mv = e_mv; v.e_w = e_w;
        v.e_busy = e_busy; v.e_src = e_src; v.e_maddr = e_maddr; v.e_widx = e_widx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        if (m_active) n_drop++;
        m_active    = 1'b0;
        m_stage     = 0;
        m_waits     = 0;
        m_tmo_pulse = 1'b0;
        m_last_d    = 1'b1;
        acc_i       = 1'b0;
        acc_d       = 1'b0;
    endtask

    task automatic idle_inputs();
        ic_req_valid = 1'b0; ic_req_addr = '0;
        dc_req_valid = 1'b0; dc_req_addr = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        fifo_full = 1'b0; fifo_is_read = 1'b0;
    endtask

    // Called at a falling edge with inputs set: compare against the model, then advance one cycle.
    task automatic tick();
        bit gi, gd, emv, ew;
        #1;
        gi  = !m_active && ic_req_valid && (!dc_req_valid || m_last_d);
        gd  = !m_active && dc_req_valid && (!ic_req_valid || !m_last_d);
        emv = m_active && (m_stage == 0);
        ew  = m_active && (m_stage == 2) && !fifo_full && !fifo_is_read;
        chk("ic_req_ready", ic_req_ready, gi);
        chk("dc_req_ready", dc_req_ready, gd);
        chk("mem_req_valid", mem_req_valid, emv);
        chk("fifo_is_write", fifo_is_write, ew);
        chk("busy", busy, m_active);
        chk("timeout_err", timeout_err, m_tmo_pulse);
        if (emv) chk("mem_req_addr", mem_req_addr, {m_addr[AW-1:OB], 6'b0});
        if (ew) begin
            chk("fifo_write_data", fifo_write_data, m_line);
            chk("fifo_write_addr", fifo_write_addr, m_addr[OB+IB-1:OB]);
        end
        if (m_active) chk("refill_src", refill_src, m_src);
        if (ic_req_ready) obs_src.push_back(0);
        if (dc_req_ready) obs_src.push_back(1);
        if (fifo_is_write) begin
            n_wr_obs++;
            last_wdata = fifo_write_data;
        end
        if (timeout_err) n_tmo_obs++;
        if (count_wait && busy && !mem_req_valid) wait_cycles++;

        acc_i = gi;
        acc_d = gd;
        m_tmo_pulse = 1'b0;
        if (!m_active) begin
            if (gi || gd) begin
                m_active = 1'b1;
                m_stage  = 0;
                m_src    = gd;
                m_addr   = gd ? dc_req_addr : ic_req_addr;
                m_last_d = gd;
                n_accept++;
            end
        end else begin
            case (m_stage)
                0: if (mem_req_ready) begin m_stage = 1; m_waits = 0; end
                1: begin
                    if (mem_rsp_valid) begin
                        m_line  = mem_rsp_data;
                        m_stage = 2;
                    end else begin
                        m_waits++;
                        if (m_waits == TMO) begin
                            m_active    = 1'b0;
                            m_tmo_pulse = 1'b1;
                            n_tmo++;
                        end
                    end
                end
                default: if (!fifo_full && !fifo_is_read) begin m_active = 1'b0; n_push++; end
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        ic_req_valid = 1'b0; dc_req_valid = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        fifo_full = 1'b0; fifo_is_read = 1'b0;
        for (int k = 0; k < 20 && m_active; k++) tick();
        #1;
        chk("drain_busy", busy, 1'b0);
        @(negedge clk);
    endtask

    logic [LW-1:0] pat_a5;
    logic [LW-1:0] d1;
    int            w0, t0;
    bit            exp_ord[4];

    initial begin
        pat_a5 = {64{8'hA5}};
        exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};

        //        icv ica          dcv dca          mrr rsp ful rd  icr dcr mv  w   bsy src maddr        widx
        vecs[0]  = mkv(1, 32'h0000_1A48, 0, 32'h0,        0,  0,  0,  0,  1,  0,  0,  0,  0,  0,  32'h0,       7'h00);
        vecs[1]  = mkv(0, 32'h0,         0, 32'h0,        1,  0,  0,  0,  0,  0,  1,  0,  1,  0,  32'h0000_1A40, 7'h00);
        vecs[2]  = mkv(0, 32'h0,         0, 32'h0,        0,  1,  0,  0,  0,  0,  0,  0,  1,  0,  32'h0,       7'h00);
        vecs[3]  = mkv(0, 32'h0,         0, 32'h0,        0,  0,  0,  0,  0,  0,  0,  1,  1,  0,  32'h0,       7'h69);
        vecs[4]  = mkv(0, 32'h0,         0, 32'h0,        0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  32'h0,       7'h00);
        vecs[5]  = mkv(0, 32'h0,         1, 32'h0000_3FC8, 0,  0,  0,  0,  0,  1,  0,  0,  0,  0,  32'h0,       7'h00);
        vecs[6]  = mkv(0, 32'h0,         0, 32'h0,        0,  0,  0,  0,  0,  0,  1,  0,  1,  1,  32'h0000_3FC0, 7'h00);
        vecs[7]  = mkv(0, 32'h0,         0, 32'h0,        1,  0,  0,  0,  0,  0,  1,  0,  1,  1,  32'h0000_3FC0, 7'h00);
        vecs[8]  = mkv(0, 32'h0,         0, 32'h0,        0,  1,  0,  0,  0,  0,  0,  0,  1,  1,  32'h0,       7'h00);
        vecs[9]  = mkv(0, 32'h0,         0, 32'h0,        0,  0,  0,  1,  0,  0,  0,  0,  1,  1,  32'h0,       7'h00);
        vecs[10] = mkv(0, 32'h0,         0, 32'h0,        0,  0,  0,  0,  0,  0,  0,  1,  1,  1,  32'h0,       7'h7F);
        vecs[11] = mkv(0, 32'h0,         0, 32'h0,        0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  32'h0,       7'h00);

        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_req_addr", mem_req_addr, '0);
        chk("rst_fifo_is_write", fifo_is_write, 1'b0);
        chk("rst_fifo_write_data", fifo_write_data, '0);
        chk("rst_fifo_write_addr", fifo_write_addr, '0);
        chk("rst_refill_src", refill_src, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed vectors: zero-wait I miss, then a D miss with a delayed accept and a FIFO read collision.
        for (int i = 0; i < 12; i++) begin
            ic_req_valid = vecs[i].icv; ic_req_addr = vecs[i].ica;
            dc_req_valid = vecs[i].dcv; dc_req_addr = vecs[i].dca;
            mem_req_ready = vecs[i].mrr; mem_rsp_valid = vecs[i].rspv; mem_rsp_data = pat_a5;
            fifo_full = vecs[i].full; fifo_is_read = vecs[i].rd;
            #1;
            chk($sformatf("vec%0d_ic_ready", i), ic_req_ready, vecs[i].e_icr);
            chk($sformatf("vec%0d_dc_ready", i), dc_req_ready, vecs[i].e_dcr);
            chk($sformatf("vec%0d_mem_valid", i), mem_req_valid, vecs[i].e_mv);
            chk($sformatf("vec%0d_fifo_write", i), fifo_is_write, vecs[i].e_w);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            if (vecs[i].e_busy) chk($sformatf("vec%0d_src", i), refill_src, vecs[i].e_src);
            if (vecs[i].e_mv) chk($sformatf("vec%0d_maddr", i), mem_req_addr, vecs[i].e_maddr);
            if (vecs[i].e_w) begin
                chk($sformatf("vec%0d_widx", i), fifo_write_addr, vecs[i].e_widx);
                chk($sformatf("vec%0d_wdata", i), fifo_write_data, pat_a5);
            end
            tick();
        end

        // Both caches missing continuously: grants alternate starting with I.
        idle_inputs();
        obs_src.delete();
        ic_req_valid = 1'b1; ic_req_addr = 32'h0000_0100;
        dc_req_valid = 1'b1; dc_req_addr = 32'h0000_2000;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = pat_a5;
        for (int k = 0; k < 40 && obs_src.size() < 4; k++) begin
            tick();
            if (acc_i) ic_req_addr = ic_req_addr + 32'h40;
            if (acc_d) dc_req_addr = dc_req_addr + 32'h40;
        end
        chk("rr_grant_count", obs_src.size(), 4);
        for (int k = 0; k < 4 && k < obs_src.size(); k++)
            chk($sformatf("rr_grant%0d", k), obs_src[k], exp_ord[k]);
        drain();

        // FIFO full for five cycles in PUSH: no write until it drops, data held.
        idle_inputs();
        d1 = {16{32'hC0DE_0001}};
        ic_req_valid = 1'b1; ic_req_addr = 32'h0000_0C80;
        tick();
        ic_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = d1;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = ~d1; fifo_full = 1'b1;
        w0 = n_wr_obs;
        repeat (5) tick();
        chk("full_no_write", n_wr_obs - w0, 0);
        fifo_full = 1'b0;
        tick();
        chk("full_one_write", n_wr_obs - w0, 1);
        chk("full_data_held", last_wdata, d1);
        drain();

        // FIFO read strobe in PUSH defers the write by one cycle.
        idle_inputs();
        dc_req_valid = 1'b1; dc_req_addr = 32'h0000_5540;
        tick();
        dc_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = pat_a5;
        tick();
        mem_rsp_valid = 1'b0; fifo_is_read = 1'b1;
        w0 = n_wr_obs;
        tick();
        chk("read_defer_no_write", n_wr_obs - w0, 0);
        fifo_is_read = 1'b0;
        tick();
        tick();
        chk("read_defer_one_write", n_wr_obs - w0, 1);
        drain();

        // No response: abandon after 1023 wait cycles, then ignore a late response.
        idle_inputs();
        t0 = n_tmo_obs; w0 = n_wr_obs;
        wait_cycles = 0; count_wait = 1'b1;
        dc_req_valid = 1'b1; dc_req_addr = 32'h0000_ABC0;
        tick();
        dc_req_valid = 1'b0; mem_req_ready = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            tick();
            if (n_tmo_obs > t0) break;
        end
        count_wait = 1'b0;
        chk("tmo_seen", n_tmo_obs - t0, 1);
        chk("tmo_wait_cycles", wait_cycles, TMO);
        mem_rsp_valid = 1'b1; mem_rsp_data = pat_a5;
        repeat (3) tick();
        chk("tmo_late_rsp_no_write", n_wr_obs - w0, 0);
        chk("tmo_idle", busy, 1'b0);
        drain();

        // Reset while waiting for memory: outputs clear at once, stale response ignored.
        idle_inputs();
        ic_req_valid = 1'b1; ic_req_addr = 32'h1234_5600;
        tick();
        ic_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("mid_rst_mem_req_addr", mem_req_addr, '0);
        chk("mid_rst_fifo_write_addr", fifo_write_addr, '0);
        chk("mid_rst_refill_src", refill_src, 1'b0);
        chk("mid_rst_timeout_err", timeout_err, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        w0 = n_wr_obs;
        mem_rsp_valid = 1'b1; mem_rsp_data = ~pat_a5;
        tick();
        tick();
        chk("post_rst_rsp_ignored", n_wr_obs - w0, 0);
        mem_rsp_valid = 1'b0;
        ic_req_valid = 1'b1; ic_req_addr = 32'h0000_0040;
        tick();
        ic_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = pat_a5;
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        chk("post_rst_refill", n_wr_obs - w0, 1);
        chk("post_rst_data", last_wdata, pat_a5);
        drain();

        // Random traffic; requesters hold valid and address until accepted.
        idle_inputs();
        acc_i = 1'b0; acc_d = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!ic_req_valid || acc_i) begin
                ic_req_valid = ($urandom_range(0, 2) == 0);
                ic_req_addr  = $urandom();
            end
            if (!dc_req_valid || acc_d) begin
                dc_req_valid = ($urandom_range(0, 2) == 0);
                dc_req_addr  = $urandom();
            end
            mem_req_ready = $urandom_range(0, 1) == 1;
            mem_rsp_valid = ($urandom_range(0, 9) < 3);
            for (int k = 0; k < 16; k++) mem_rsp_data[k*32 +: 32] = $urandom();
            fifo_full    = ($urandom_range(0, 3) == 0);
            fifo_is_read = ($urandom_range(0, 4) == 0);
            tick();
        end
        drain();

        chk("sb_balance", n_accept, n_push + n_tmo + n_drop);
        chk("sb_write_count", n_wr_obs, n_push);
        chk("sb_timeout_count", n_tmo_obs, n_tmo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
